seq_div_sign: RTL and testbench
===============================

// Module: seq_div_sign
// PURPOSE
//   Multi-cycle signed (two's complement) divider: Q = A / B, R = A % B, truncating toward zero.
//   Inverse companion of the combinational signed multiplier in the 5-bit ALU datapath.
//   Sits beside the ALU as a start/busy/done coprocessor, so the ALU's combinational result path is never stalled.
//   Restoring shift-subtract on magnitudes: one quotient bit per clock, sign fix-up in a final cycle.
// PARAMETERS
//   N   5   operand width in bits (dividend and divisor, two's complement); N >= 2
// PORTS
//   clk     in   1     single clock, all state updates on rising edge
//   rst_n   in   1     synchronous, active-low reset (sampled on rising clk edge)
//   start   in   1     request; accepted only on an edge where state = IDLE
//   a       in   N     dividend, signed; sampled on the accepting edge only
//   b       in   N     divisor, signed; sampled on the accepting edge only
//   q       out  N+1   quotient, signed, sign-extended to N+1 bits (holds +2^(N-1))
//   r       out  N     remainder, signed; sign follows dividend, |r| < |b|
//   div0    out  1     b was zero for the result currently on q/r
//   busy    out  1     high while a division is in progress
//   done    out  1     one-cycle pulse: q/r/div0 are valid from this cycle onward
// BEHAVIOUR
//   Reset (rst_n=0 at an edge, any state, including mid-division):
//     state=IDLE; q=0, r=0, div0=0, busy=0, done=0; the in-flight operation is discarded, no done pulse.
//   States: IDLE -> RUN -> FIX -> IDLE.
//   IDLE:
//     - start=1 at edge E0: latch sign(a), sign(b), |a|, |b| (N-bit unsigned; |-2^(N-1)| = 2^(N-1) fits).
//     - On the same edge: partial remainder P (N+1 bits) = 0, cnt = N, busy <= 1, done <= 0, next = RUN.
//     - start=0: hold state; q/r/div0 keep their last values.
//   RUN (edges E0+1 .. E0+N):
//     - Each edge: {P,D} shift left 1; if P >= |b| then P -= |b| and the new quotient bit = 1, else 0.
//     - cnt decrements each edge; the edge where cnt goes 1 -> 0 moves to FIX.
//   FIX (edge E0+N+1):
//     - q <= (sign(a)^sign(b)) ? -mag_q : mag_q, computed at N+1 bits.
//     - r <= sign(a) ? -P : P, truncated to N bits.
//     - busy <= 0, done <= 1, next = IDLE.
//   Latency: done is high in the cycle after edge E0+N+1 (N+1 edges after acceptance; 6 for N=5).
//     busy is high for exactly N+1 cycles. Uniform latency for all operand values, including b=0.
//   done: high for exactly one cycle; q/r/div0 then hold until the next FIX edge or reset.
//   Divide by zero (b=0):
//     - Runs the same state sequence, no early exit.
//     - FIX forces q = 0, r = a, div0 = 1.
//     - div0 is cleared at the FIX of the next non-zero division.
//   Overflow case a = -2^(N-1), b = -1: q = +2^(N-1) (N+1 bits, no overflow), r = 0.
//   start while busy=1: ignored entirely; no queueing, no effect on the running operation.
//   start high in the done cycle: state is IDLE, so it is accepted.
//     Back-to-back throughput is one result per N+1 cycles.
//   a and b may change freely after the accepting edge; only the latched copies are used.
//   Outputs are registered only; no combinational input-to-output path.
// TESTING (N=5, widths: q 6b, r 5b)
//   1 reset, start a=13 b=4 -> done 6 edges after accept; q=3 (6'h03), r=1, div0=0; busy high for 6 cycles.
//   2 sign sweep:
//     a=-13 b=4  -> q=-3 (6'h3D), r=-1 (5'h1F)
//     a=13  b=-4 -> q=-3, r=1
//     a=-13 b=-4 -> q=3, r=-1
//     a=-16 b=-1 -> q=+16 (6'h10), r=0
//     a=-16 b=1  -> q=-16 (6'h30), r=0
//   3 a=7 b=0 -> done at same latency; q=0, r=7, div0=1; then a=9 b=3 -> q=3, r=0, div0=0.
//   4 start pulsed on edges 2 and 4 after accept (a=1 b=1) while busy -> ignored; original a=15 b=2 gives q=7, r=1.
//     start held in the done cycle -> second op accepted; two done pulses exactly 6 cycles apart.
//   5 rst_n=0 for one edge at cnt=2 mid-RUN -> busy=0, done=0, q=0, r=0, no later done.
//     Next start completes normally.
//   6 random scoreboard: 2000 ops, all 32x32 operand pairs covered, against a truncating-division model;
//     assert |r|<|b|, a == q*b + r (b!=0), done never high two cycles in a row.

Source files
------------

// File: rtl/seq_div_sign_if.sv
// ---------------------------------------------------------------------------
// seq_div_sign_if
//   Handshake/data bundle between a requester (ALU sequencer or testbench)
//   and the seq_div_sign divider coprocessor.
//
//   Signals (N = operand width):
//     start  requester -> divider  1     request, honoured only while idle
//     a      requester -> divider  N     dividend, two's complement
//     b      requester -> divider  N     divisor, two's complement
//     q      divider -> requester  N+1   quotient, sign-extended
//     r      divider -> requester  N     remainder, sign of dividend
//     div0   divider -> requester  1     result on q/r came from b == 0
//     busy   divider -> requester  1     division in progress
//     done   divider -> requester  1     one-cycle result-valid pulse
//
//   Modports: master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface seq_div_sign_if #(
  parameter int N = 5
) ();
  logic                start;
  logic signed [N-1:0] a;
  logic signed [N-1:0] b;
  logic signed [N:0]   q;
  logic signed [N-1:0] r;
  logic                div0;
  logic                busy;
  logic                done;

  modport master (
    output start, a, b,
    input  q, r, div0, busy, done
  );

  modport slave (
    input  start, a, b,
    output q, r, div0, busy, done
  );
endinterface

// File: rtl/seq_div_sign.sv
// ---------------------------------------------------------------------------
// seq_div_sign
//   Multi-cycle signed divider, Q = A / B and R = A % B truncating toward
//   zero. Restoring shift-subtract on operand magnitudes produces one
//   quotient bit per clock; a final cycle applies the signs. Sits beside the
//   ALU as a start/busy/done coprocessor.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   synchronous active-low reset; discards any operation
//     bus    slave modport of seq_div_sign_if (start/a/b in,
//            q/r/div0/busy/done out, all outputs registered)
//
//   Timing: accept on edge E0, N RUN edges, FIX on edge E0+N+1; done is high
//   for the single cycle after FIX. Latency is identical for every operand
//   pair, including b == 0.
// ---------------------------------------------------------------------------
module seq_div_sign #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div_sign_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Control state (reset)
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic signed [N:0]   r_q;
  logic signed [N-1:0] r_r;
  logic                r_div0;
  logic                r_busy;
  logic                r_done;

  // Operand / datapath state (loaded on accept, not reset)
  logic                r_sa;    // sign of dividend
  logic                r_sb;    // sign of divisor
  logic [N-1:0]        r_ma;    // |a| shifting out, quotient bits shifting in
  logic [N-1:0]        r_mb;    // |b|
  logic [N-1:0]        r_p;     // partial remainder, always < |b| so N bits suffice
  logic signed [N-1:0] r_a;     // raw dividend, returned as r on divide-by-zero

  logic [N:0]          w_shift;
  logic [N-1:0]        w_trial;
  logic                w_ge;

  // Magnitude of a two's complement value; |-2^(N-1)| = 2^(N-1) fits unsigned.
  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] v);
    logic signed [N-1:0] n;
    n = -v;
    return v[N-1] ? unsigned'(n) : unsigned'(v);
  endfunction

  // Quotient sign fix-up at N+1 bits so +2^(N-1) is representable.
  function automatic logic signed [N:0] apply_sign_q(input logic neg,
                                                     input logic [N-1:0] mag);
    logic signed [N:0] ext;
    ext = $signed({1'b0, mag});
    return neg ? -ext : ext;
  endfunction

  // Remainder takes the dividend's sign.
  function automatic logic signed [N-1:0] apply_sign_r(input logic neg,
                                                       input logic [N-1:0] p);
    logic signed [N-1:0] t;
    t = $signed(p);
    return neg ? -t : t;
  endfunction

  // Restoring step: bring in the next dividend bit and trial-subtract |b|.
  // The N+1-bit shift can only set its top bit when it already exceeds |b|,
  // so the N-bit difference is exact whenever it is kept.
  assign w_shift = {r_p, r_ma[N-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mb});
  assign w_trial = w_shift[N-1:0] - r_mb;

  // ---- datapath: operand capture and shift-subtract iterations ----
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          r_sa <= bus.a[N-1];
          r_sb <= bus.b[N-1];
          r_ma <= magnitude(bus.a);
          r_mb <= magnitude(bus.b);
          r_a  <= bus.a;
          r_p  <= '0;
        end
      end
      RUN: begin
        r_p  <= w_ge ? w_trial : w_shift[N-1:0];
        r_ma <= {r_ma[N-2:0], w_ge};
      end
      default: ;
    endcase
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_cnt   <= CW'(N);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          // b == 0 runs the full sequence; only the result is overridden here.
          if (r_mb == '0) begin
            r_q    <= '0;
            r_r    <= r_a;
            r_div0 <= 1'b1;
          end else begin
            r_q    <= apply_sign_q(r_sa ^ r_sb, r_ma);
            r_r    <= apply_sign_r(r_sa, r_p);
            r_div0 <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.div0 = r_div0;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_seq_div_sign.sv
// ---------------------------------------------------------------------------
// tb_seq_div_sign
//   Directed and exhaustive/random checks of seq_div_sign (N = 5). A
//   behavioural model (integer division plus a "result lands N+1 edges after
//   acceptance" timing rule) is compared against busy/done/q/r/div0 on every
//   falling edge; literal checks pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_seq_div_sign;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_div_sign_if #(.N(N)) dif ();

  seq_div_sign #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;          // number of rising edges so far
  int rst_cyc = -100;   // edge index of the most recent reset edge

  // Model of the operation in flight and of the held outputs
  bit pending = 1'b0;
  int acc = -100;       // edge index at which the operation was accepted
  int last_done = -100;
  int pa = 0, pb = 0, pq = 0, pr = 0;
  bit pd = 1'b0;
  int hq = 0, hr = 0;
  bit hd = 1'b0;
  bit prev_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Edge counter and reset-edge detector
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) rst_cyc = cyc;
    end
  end

  // Compare process: model outputs versus DUT on every falling edge
  initial begin
    bit eb, ed;
    int dq, dr, mag_r, mag_b;
    forever begin
      @(negedge clk);
      if (cyc == rst_cyc) begin
        pending   = 1'b0;
        hq        = 0;
        hr        = 0;
        hd        = 1'b0;
        last_done = -100;
      end else if (pending && cyc == acc + N + 1) begin
        hq        = pq;
        hr        = pr;
        hd        = pd;
        pending   = 1'b0;
        last_done = cyc;
        dq = int'(dif.q);
        dr = int'(dif.r);
        if (pb != 0) begin
          mag_r = (dr < 0) ? -dr : dr;
          mag_b = (pb < 0) ? -pb : pb;
          chk("rem_bound", int'(mag_r < mag_b), 1);
          chk("identity", dq * pb + dr, pa);
        end
      end
      ed = (cyc == last_done);
      eb = pending && (cyc >= acc) && (cyc <= acc + N);
      chk("busy", int'(dif.busy), int'(eb));
      chk("done", int'(dif.done), int'(ed));
      chk("q", int'(dif.q), hq);
      chk("r", int'(dif.r), hr);
      chk("div0", int'(dif.div0), int'(hd));
      chk("done_twice", int'(prev_done & dif.done), 0);
      prev_done = dif.done;
    end
  end

  // Drive a request for one cycle and record the model's expectation.
  task automatic start_op(input int a, input int b);
    dif.a     = N'(a);
    dif.b     = N'(b);
    dif.start = 1'b1;
    pa  = a;
    pb  = b;
    pd  = (b == 0);
    pq  = (b == 0) ? 0 : a / b;
    pr  = (b == 0) ? a : a % b;
    acc = cyc + 1;
    pending = 1'b1;
  endtask

  // Full operation; returns in the done cycle so the next call is back-to-back.
  task automatic run_op(input int a, input int b);
    start_op(a, b);
    tick();
    dif.start = 1'b0;
    dif.a = N'($urandom);
    dif.b = N'($urandom);
    repeat (N + 1) tick();
  endtask

  initial begin
    int ta [5] = '{-13, 13, -13, -16, -16};
    int tb [5] = '{4, -4, -4, -1, 1};
    int tqb[5] = '{'h3D, 'h3D, 'h03, 'h10, 'h30};
    int trb[5] = '{'h1F, 'h01, 'h1F, 'h00, 'h00};
    int ra, rb;

    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_q", int'($unsigned(dif.q)), 0);
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);

    // 1: basic positive division
    run_op(13, 4);
    chk("t1_q", int'($unsigned(dif.q)), 'h03);
    chk("t1_r", int'($unsigned(dif.r)), 1);
    chk("t1_div0", int'(dif.div0), 0);
    chk("t1_model_q", hq, 3);
    chk("t1_model_r", hr, 1);

    // 2: sign sweep and the -2^(N-1) corners
    for (int i = 0; i < 5; i++) begin
      tick();
      run_op(ta[i], tb[i]);
      chk($sformatf("t2_q_%0d", i), int'($unsigned(dif.q)), tqb[i]);
      chk($sformatf("t2_r_%0d", i), int'($unsigned(dif.r)), trb[i]);
    end

    // 3: divide by zero, then div0 cleared by a normal division
    tick();
    run_op(7, 0);
    chk("t3_q", int'($unsigned(dif.q)), 0);
    chk("t3_r", int'($unsigned(dif.r)), 7);
    chk("t3_div0", int'(dif.div0), 1);
    run_op(9, 3);
    chk("t3b_q", int'($unsigned(dif.q)), 3);
    chk("t3b_r", int'($unsigned(dif.r)), 0);
    chk("t3b_div0", int'(dif.div0), 0);

    // 4: start pulses while busy are ignored; start in done cycle accepted
    tick();
    start_op(15, 2);
    tick();
    dif.start = 1'b0;
    tick();
    dif.a = N'(1);
    dif.b = N'(1);
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    tick();
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    chk("t4_q", int'($unsigned(dif.q)), 7);
    chk("t4_r", int'($unsigned(dif.r)), 1);
    chk("t4_done", int'(dif.done), 1);
    run_op(-11, 3);
    chk("t4b_q", int'($unsigned(dif.q)), 'h3D);
    chk("t4b_r", int'($unsigned(dif.r)), 'h1E);

    // 5: reset mid-RUN discards the operation
    tick();
    start_op(13, 4);
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_busy", int'(dif.busy), 0);
    chk("t5_done", int'(dif.done), 0);
    chk("t5_q", int'($unsigned(dif.q)), 0);
    chk("t5_r", int'($unsigned(dif.r)), 0);
    repeat (10) tick();
    run_op(-7, 2);
    chk("t5b_q", int'(dif.q), -3);
    chk("t5b_r", int'(dif.r), -1);

    // 6: every operand pair, then random pairs, back-to-back
    for (int ia = -16; ia < 16; ia++) begin
      for (int ib = -16; ib < 16; ib++) begin
        run_op(ia, ib);
      end
    end
    for (int k = 0; k < 976; k++) begin
      ra = int'($urandom_range(31)) - 16;
      rb = int'($urandom_range(31)) - 16;
      run_op(ra, rb);
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
